muldiv_issue: RTL

MULDIV_ISSUE -- requirements
Module: muldiv_issue

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_sign_fix.sv | 33 +++
 rtl/muldiv_issue.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension issue controller.
//   XLEN          default operand/result width
//   op_e          funct3 encoding of the eight M-extension ops
//   state_e       issue FSM states
//   result_is_hi  true when the op returns the hi half (high product or remainder)
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_e;

    // The unit returns {hi,lo} = product or {remainder, quotient}.
    function automatic logic result_is_hi(op_e op);
        return !(op inside {OP_MUL, OP_DIV, OP_DIVU});
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational conditional negation for the M-extension datapath.
// Used twice: on the operands (hi=rs1, lo=rs2, wide=0) it yields magnitudes;
// on the unit results it applies the sign correction, either to the whole
// 2*XLEN product (wide=1) or separately to remainder (hi) and quotient (lo).
//   hi_in, lo_in    in   XLEN  values to fix
//   wide            in   1     negate {hi,lo} as one number under neg_hi
//   neg_hi, neg_lo  in   1     negate enables (neg_lo unused when wide=1)
//   hi_out, lo_out  out  XLEN  corrected values
module muldiv_sign_fix #(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic            wide,
    input  logic            neg_hi,
    input  logic            neg_lo,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [2*XLEN-1:0] wide_v;

    always_comb begin
        wide_v = neg_hi ? -{hi_in, lo_in} : {hi_in, lo_in};
        if (wide) begin
            {hi_out, lo_out} = wide_v;
        end else begin
            hi_out = neg_hi ? -hi_in : hi_in;
            lo_out = neg_lo ? -lo_in : lo_in;
        end
    end

endmodule

// File: rtl/muldiv_issue.sv
// Issue/response controller between the EX stage and an iterative
// shift/add-subtract multiply/divide unit. Handles the divide special cases
// locally, caches the last unit result (keyed on magnitudes and mul/div)
// and applies sign correction to unit results.
//   Clk, Reset                in   clock, synchronous active-high reset
//   req_valid, funct3         in   request and M-extension op
//   rs1_data, rs2_data        in   operands, stable while req_valid
//   kill                      in   abandon the current request
//   stall                     out  freeze the pipeline
//   result, result_valid      out  rd value and its one-cycle strobe
//   unit_execute              out  one-cycle start pulse to the unit
//   unit_a, unit_b, unit_div  out  unsigned magnitudes and mul/div select
//   unit_ready                in   unit done (level, cleared by unit_execute)
//   unit_hi, unit_lo          in   {hi,lo} product or {remainder, quotient}
module muldiv_issue #(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            req_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            kill,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            unit_execute,
    output logic [XLEN-1:0] unit_a,
    output logic [XLEN-1:0] unit_b,
    output logic            unit_div,
    input  logic            unit_ready,
    input  logic [XLEN-1:0] unit_hi,
    input  logic [XLEN-1:0] unit_lo
);
    import muldiv_pkg::*;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    state_e          state_q, state_d;
    logic            first_q, first_d;
    op_e             op_q, op_d;
    logic            a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic [XLEN-1:0] unit_a_q, unit_a_d, unit_b_q, unit_b_d;
    logic            unit_div_q, unit_div_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            cache_v_q, cache_v_d;
    logic [XLEN-1:0] cache_hi_q, cache_hi_d, cache_lo_q, cache_lo_d;
    logic [XLEN-1:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
    logic            cache_div_q, cache_div_d;

    op_e             req_op;
    logic            req_div, a_signed, b_signed, req_a_neg, req_b_neg;
    logic            div_zero, div_ovf, cache_hit;
    logic [XLEN-1:0] mag_a, mag_b;

    logic            in_idle, fix_div, fix_a_neg, fix_b_neg;
    op_e             fix_op;
    logic [XLEN-1:0] raw_hi, raw_lo, fix_hi, fix_lo, fix_result;

    always_comb begin
        req_op    = op_e'(funct3);
        req_div   = funct3[2];
        a_signed  = req_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed  = req_op inside {OP_MULH, OP_DIV, OP_REM};
        req_a_neg = a_signed & rs1_data[XLEN-1];
        req_b_neg = b_signed & rs2_data[XLEN-1];
        div_zero  = req_div && (rs2_data == '0);
        div_ovf   = (req_op inside {OP_DIV, OP_REM}) && (rs1_data == INT_MIN)
                    && (rs2_data == ALL_ONES);
        cache_hit = cache_v_q && (cache_div_q == req_div)
                    && (cache_a_q == mag_a) && (cache_b_q == mag_b);
    end

    muldiv_sign_fix #(.XLEN(XLEN)) u_opnd_fix (
        .hi_in  (rs1_data),
        .lo_in  (rs2_data),
        .wide   (1'b0),
        .neg_hi (req_a_neg),
        .neg_lo (req_b_neg),
        .hi_out (mag_a),
        .lo_out (mag_b)
    );

    // A cache hit is resolved in IDLE with the live request's signs; a unit
    // result is resolved in WAIT with the signs latched at acceptance.
    always_comb begin
        in_idle   = (state_q == S_IDLE);
        fix_op    = in_idle ? req_op    : op_q;
        fix_div   = in_idle ? req_div   : unit_div_q;
        fix_a_neg = in_idle ? req_a_neg : a_neg_q;
        fix_b_neg = in_idle ? req_b_neg : b_neg_q;
        raw_hi    = in_idle ? cache_hi_q : unit_hi;
        raw_lo    = in_idle ? cache_lo_q : unit_lo;
    end

    // Remainder follows the dividend; product and quotient follow sign XOR.
    muldiv_sign_fix #(.XLEN(XLEN)) u_res_fix (
        .hi_in  (raw_hi),
        .lo_in  (raw_lo),
        .wide   (~fix_div),
        .neg_hi (fix_div ? fix_a_neg : (fix_a_neg ^ fix_b_neg)),
        .neg_lo (fix_a_neg ^ fix_b_neg),
        .hi_out (fix_hi),
        .lo_out (fix_lo)
    );

    assign fix_result = result_is_hi(fix_op) ? fix_hi : fix_lo;

    always_comb begin
        state_d     = state_q;
        first_d     = 1'b0;
        op_d        = op_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        unit_a_d    = unit_a_q;
        unit_b_d    = unit_b_q;
        unit_div_d  = unit_div_q;
        result_d    = result_q;
        cache_v_d   = cache_v_q;
        cache_hi_d  = cache_hi_q;
        cache_lo_d  = cache_lo_q;
        cache_a_d   = cache_a_q;
        cache_b_d   = cache_b_q;
        cache_div_d = cache_div_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !kill) begin
                    if (div_zero) begin
                        result_d = result_is_hi(req_op) ? rs1_data : ALL_ONES;
                        state_d  = S_RESP;
                    end else if (div_ovf) begin
                        result_d = result_is_hi(req_op) ? '0 : INT_MIN;
                        state_d  = S_RESP;
                    end else if (cache_hit) begin
                        result_d = fix_result;
                        state_d  = S_RESP;
                    end else begin
                        unit_a_d   = mag_a;
                        unit_b_d   = mag_b;
                        unit_div_d = req_div;
                        op_d       = req_op;
                        a_neg_d    = req_a_neg;
                        b_neg_d    = req_b_neg;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = kill ? S_DRAIN : S_WAIT;
                first_d = 1'b1;
            end
            S_WAIT: begin
                // unit_ready is stale from the previous op in the first cycle.
                if (kill) begin
                    state_d = S_DRAIN;
                    first_d = 1'b1;
                end else if (!first_q && unit_ready) begin
                    result_d    = fix_result;
                    cache_v_d   = 1'b1;
                    cache_hi_d  = unit_hi;
                    cache_lo_d  = unit_lo;
                    cache_a_d   = unit_a_q;
                    cache_b_d   = unit_b_q;
                    cache_div_d = unit_div_q;
                    state_d     = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_DRAIN: begin
                if (!first_q && unit_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            first_q    <= 1'b0;
            cache_v_q  <= 1'b0;
            result_q   <= '0;
            unit_a_q   <= '0;
            unit_b_q   <= '0;
            unit_div_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            cache_v_q  <= cache_v_d;
            result_q   <= result_d;
            unit_a_q   <= unit_a_d;
            unit_b_q   <= unit_b_d;
            unit_div_q <= unit_div_d;
        end
    end

    // Data-only state; meaningless while cache_v_q / the FSM say so.
    always_ff @(posedge Clk) begin
        op_q        <= op_d;
        a_neg_q     <= a_neg_d;
        b_neg_q     <= b_neg_d;
        cache_hi_q  <= cache_hi_d;
        cache_lo_q  <= cache_lo_d;
        cache_a_q   <= cache_a_d;
        cache_b_q   <= cache_b_d;
        cache_div_q <= cache_div_d;
    end

    assign result_valid = (state_q == S_RESP) && !kill;
    assign stall        = req_valid && !result_valid && !kill && !Reset;
    assign unit_execute = (state_q == S_ISSUE);
    assign result       = result_q;
    assign unit_a       = unit_a_q;
    assign unit_b       = unit_b_q;
    assign unit_div     = unit_div_q;

endmodule
